param_serializer: RTL and testbench
===================================

PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 Parameter DATA_W, default 16: parallel word width, legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(DATA_W+1): width of the bit-count input.
REQ-003 Parameter LSB_FIRST, default 0: 0 sends data_i[DATA_W-1] first, 1 sends data_i[0] first.
REQ-004 clk_i  in  1  single clock; all logic is clocked on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 data_val_i  in  1  word-valid strobe, sampled on the clock, level-sensitive (no edge detection).
REQ-007 data_i  in  DATA_W  parallel word to serialize.
REQ-008 data_mod_i  in  CNT_W  number of bits to send, taken from the significant end selected by LSB_FIRST.
REQ-009 ser_ready_i  in  1  downstream ready; a bit transfers on a cycle with ser_data_val_o=1 and ser_ready_i=1.
REQ-010 ser_data_o  out  1  serial data bit.
REQ-011 ser_data_val_o  out  1  serial data valid.
REQ-012 ser_last_o  out  1  marks the final bit of a word; qualified by ser_data_val_o.
REQ-013 busy_o  out  1  high while a word is held; new words are accepted only when busy_o=0.
REQ-014 drop_o  out  1  one-cycle pulse flagging a rejected data_val_i.

Function
REQ-015 All outputs SHALL be registered; there is no combinational input-to-output path.
REQ-016 The FSM SHALL have two states, IDLE and SHIFT, and SHALL use no other clock or edge source.
REQ-017 Accept: in IDLE with data_val_i=1 and 1<=data_mod_i<=DATA_W, the block SHALL capture data_i and data_mod_i and enter SHIFT on the next edge.
REQ-018 Clamp: data_mod_i>DATA_W SHALL be accepted as DATA_W.
REQ-019 Zero length: data_mod_i=0 with data_val_i=1 in IDLE SHALL be ignored (no state change, drop_o=0).
REQ-020 Latency: the first bit SHALL appear with ser_data_val_o=1 in the cycle after acceptance; busy_o SHALL rise in that same cycle.
REQ-021 In SHIFT, ser_data_val_o SHALL stay 1 and the held bit SHALL stay stable until ser_ready_i=1.
REQ-022 On each transfer the block SHALL advance to the next bit and decrement the remaining count by one.
REQ-023 ser_last_o SHALL be 1 exactly when the presented bit is the last of the word.
REQ-024 Throughput: with ser_ready_i held at 1, N bits SHALL occupy exactly N consecutive cycles.
REQ-025 When the last bit transfers, the block SHALL return to IDLE, and busy_o, ser_data_val_o and ser_last_o SHALL be 0 in the next cycle.
REQ-026 Back-to-back: a word can be accepted in the first IDLE cycle, giving a one-cycle bubble between words.
REQ-027 Reject: data_val_i=1 while busy_o=1 SHALL leave the transfer in progress unaffected and pulse drop_o for one cycle per sampled cycle.
REQ-028 In IDLE, ser_data_o SHALL be 0.
REQ-029 The internal bit counter SHALL be CNT_W wide and SHALL never wrap below zero.
REQ-030 The block SHALL never send more than DATA_W bits per word.

Reset
REQ-031 When rst_i=1 at a clock edge, the block SHALL enter IDLE and drive ser_data_o=0, ser_data_val_o=0, ser_last_o=0, busy_o=0 and drop_o=0 from the next cycle.
REQ-032 Reset mid-word SHALL abort the word: no further bits are sent and the remaining bits are discarded.
REQ-033 rst_i SHALL take priority over data_val_i in the same cycle; that word is not accepted.
REQ-034 The first acceptance SHALL be possible in the cycle after rst_i deasserts.

Verification
REQ-035 DATA_W=16, LSB_FIRST=0, ser_ready_i=1, data_i=16'hAAAA, data_mod_i=4 -> bits 1,0,1,0 on four consecutive cycles, last on the 4th bit, busy_o high for 4 cycles.
REQ-036 Same word with LSB_FIRST=1 and data_mod_i=3 -> bits 0,1,0, last on the 3rd bit.
REQ-037 Backpressure: data_mod_i=4 with ser_ready_i=0 for 3 cycles at bit 2 -> bit 2 is held stable with valid=1; the word completes in 7 cycles with no bit lost or duplicated.
REQ-038 Second data_val_i pulse at bit 1 of a 4-bit word -> one drop_o pulse and the original word completes intact; data_mod_i=0 -> no activity; data_mod_i=20 -> exactly 16 bits sent.
REQ-039 rst_i at bit 2 of an 8-bit word -> all outputs 0 in the next cycle; a new 2-bit word accepted after reset serializes correctly.
REQ-040 Back-to-back words of 2 bits each with data_val_i held at 1 -> pattern of 2 bits, 1 idle cycle, 2 bits, and drop_o pulses while busy_o=1.

Source files
------------

// File: rtl/param_serializer_if.sv
// param_serializer_if: parallel-word input and serial-bit output bundle for param_serializer
interface param_serializer_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic              data_val_i;
  logic [DATA_W-1:0] data_i;
  logic [CNT_W-1:0]  data_mod_i;
  logic              ser_ready_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              ser_last_o;
  logic              busy_o;
  logic              drop_o;
  modport master (
    output data_val_i, data_i, data_mod_i, ser_ready_i,
    input  ser_data_o, ser_data_val_o, ser_last_o, busy_o, drop_o
  );
  modport slave (
    input  data_val_i, data_i, data_mod_i, ser_ready_i,
    output ser_data_o, ser_data_val_o, ser_last_o, busy_o, drop_o
  );
endinterface

// File: rtl/param_serializer.sv
// param_serializer: sends the first data_mod_i bits of a word one per transfer with ready/valid backpressure
module param_serializer #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = $clog2(DATA_W + 1),
  parameter bit LSB_FIRST = 0
) (
  input logic             clk_i,
  input logic             rst_i,
  param_serializer_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_data;
  logic              r_busy;
  logic              r_last;
  logic              r_drop;
  logic [CNT_W-1:0]  w_len;
  logic              w_first;
  logic              w_next;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_shift;
  // Clamp over-long requests and pick the bit heads for load and advance
  always_comb begin
    w_len   = bus.data_mod_i > CNT_W'(DATA_W) ? CNT_W'(DATA_W) : bus.data_mod_i;
    w_first = LSB_FIRST ? bus.data_i[0] : bus.data_i[DATA_W-1];
    w_next  = LSB_FIRST ? r_sh[0] : r_sh[DATA_W-1];
    w_load  = LSB_FIRST ? bus.data_i >> 1 : bus.data_i << 1;
    w_shift = LSB_FIRST ? r_sh >> 1 : r_sh << 1;
  end
  // Two-state FSM; r_sh holds the bits still to be presented, r_cnt counts the presented bit too
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_data  <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= bus.data_val_i && r_state == SHIFT;
      if (r_state == IDLE) begin
        if (bus.data_val_i && bus.data_mod_i != '0) begin
          r_state <= SHIFT;
          r_sh    <= w_load;
          r_cnt   <= w_len;
          r_data  <= w_first;
          r_busy  <= 1'b1;
          r_last  <= w_len == CNT_W'(1);
        end
      end else if (bus.ser_ready_i) begin
        if (r_cnt == CNT_W'(1)) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_data  <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_sh   <= w_shift;
          r_cnt  <= r_cnt - 1'b1;
          r_data <= w_next;
          r_last <= r_cnt == CNT_W'(2);
        end
      end
    end
  end
  assign bus.ser_data_o     = r_data;
  assign bus.ser_data_val_o = r_busy;
  assign bus.ser_last_o     = r_last;
  assign bus.busy_o         = r_busy;
  assign bus.drop_o         = r_drop;
endmodule

// File: tb/tb_param_serializer.sv
// tb_param_serializer: directed checks of MSB-first and LSB-first serializer instances
module tb_param_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  param_serializer_if #(.DATA_W(16)) m ();
  param_serializer_if #(.DATA_W(16)) l ();
  param_serializer #(.DATA_W(16), .LSB_FIRST(0)) u_m (.clk_i(clk), .rst_i(rst), .bus(m));
  param_serializer #(.DATA_W(16), .LSB_FIRST(1)) u_l (.clk_i(clk), .rst_i(rst), .bus(l));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] n);
    m.data_val_i = v;
    m.data_i     = d;
    m.data_mod_i = n;
    l.data_val_i = v;
    l.data_i     = d;
    l.data_mod_i = n;
  endtask
  task automatic rdy(input logic r);
    m.ser_ready_i = r;
    l.ser_ready_i = r;
  endtask
  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_out(input string tag, input bit lsb, input logic d, input logic v,
                         input logic lst, input logic b, input logic dr);
    chk({tag, ".data"}, lsb ? l.ser_data_o : m.ser_data_o, d);
    chk({tag, ".val"}, lsb ? l.ser_data_val_o : m.ser_data_val_o, v);
    chk({tag, ".last"}, lsb ? l.ser_last_o : m.ser_last_o, lst);
    chk({tag, ".busy"}, lsb ? l.busy_o : m.busy_o, b);
    chk({tag, ".drop"}, lsb ? l.drop_o : m.drop_o, dr);
  endtask
  task automatic check_word(input string tag, input bit lsb, input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      chk_out(tag, lsb, seq[i], 1'b1, i == n - 1, 1'b1, 1'b0);
      tick();
    end
    chk_out({tag, ".idle"}, lsb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic send(input logic [15:0] d, input logic [4:0] n);
    drive(1'b1, d, n);
    tick();
    drive(1'b0, 16'h0, 5'd0);
  endtask
  initial begin
    logic [15:0] s;
    logic [5:0]  eb, ev, el, ed;
    int          idx;
    drive(1'b0, 16'h0, 5'd0);
    rdy(1'b1);
    tick();
    tick();
    chk_out("reset_m", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("reset_l", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    send(16'hAAAA, 5'd4);
    check_word("msb4", 1'b0, 16'h0005, 4);
    send(16'hAAAA, 5'd3);
    check_word("lsb3", 1'b1, 16'h0002, 3);
    s = 16'h0005;
    send(16'hAAAA, 5'd4);
    for (int c = 0; c < 7; c++) begin
      idx = c == 0 ? 0 : c <= 4 ? 1 : c - 3;
      chk_out("bp", 1'b0, s[idx], 1'b1, idx == 3, 1'b1, 1'b0);
      rdy(!(c >= 1 && c <= 3));
      tick();
    end
    chk_out("bp.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'hAAAA, 5'd4);
    for (int c = 0; c < 4; c++) begin
      chk_out("drop", 1'b0, s[c], 1'b1, c == 3, 1'b1, c == 1);
      drive(c == 0, 16'h0000, 5'd4);
      tick();
    end
    chk_out("drop.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'hAAAA, 5'd0);
    tick();
    chk_out("zero1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 5'd0);
    tick();
    chk_out("zero2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'hC3A5, 5'd20);
    check_word("clamp", 1'b0, 16'hA5C3, 16);
    send(16'hF0F0, 5'd8);
    chk_out("rst_b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("rst_b2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rst_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h4000, 5'd2);
    check_word("post_rst", 1'b0, 16'h0002, 2);
    rst = 1'b1;
    drive(1'b1, 16'hAAAA, 5'd4);
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 5'd0);
    chk_out("rst_prio1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst_prio2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    eb = 6'b001001;
    ev = 6'b011011;
    el = 6'b010010;
    ed = 6'b110110;
    drive(1'b1, 16'hAAAA, 5'd2);
    tick();
    for (int c = 0; c < 6; c++) begin
      chk_out("b2b", 1'b0, eb[c], ev[c], el[c], ev[c], ed[c]);
      if (c == 5) drive(1'b0, 16'h0, 5'd0);
      tick();
    end
    chk_out("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
